tx_wave_reader: RTL
===================

Name: tx_wave_reader

Overview:
- Read-side consumer of the dual-port sample BRAM (10-bit address, 18-bit data, 1-cycle registered read).
- Streams a stored transmit waveform (pulse or code) out of the BRAM one sample per `sample_tick` toward the TX DAC path.
- Controlled by a start/busy/done handshake.
- Drives the BRAM read port (`enb`/`addrb`/`dob`) only; the write port belongs to the loader.

Parameters:
- ADDR_W, 10, BRAM address width.
- DATA_W, 18, sample width.
- LEN_W, 11, length field width (allows 1..1024 samples).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin playback; honoured only in IDLE.
- base_addr  in  ADDR_W  first BRAM address; sampled on the accepted start.
- length  in  LEN_W  number of samples to play; sampled on the accepted start.
- sample_tick  in  1  one-cycle DAC rate strobe.
- bram_en  out  1  BRAM read enable (to enb).
- bram_addr  out  ADDR_W  BRAM read address (to addrb).
- bram_dout  in  DATA_W  BRAM read data (from dob); valid the cycle after bram_en.
- tx_data  out  DATA_W  sample to DAC.
- tx_valid  out  1  one-cycle pulse when tx_data updates with a new sample.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle completion pulse.
- underrun  out  1  sticky flag: a tick arrived before the next sample was ready.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: bram_en=0, bram_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, underrun=0.
  - Internal: state=IDLE, count=0, hold register=0.
  - Reset mid-playback aborts immediately; no done pulse.
- All outputs are registered.
- States: IDLE, PREFETCH, LOAD, READY, DRAIN.
- IDLE:
  - start=1 with length≠0: latch base_addr into rd_ptr, length into len, clear count and underrun → PREFETCH.
  - start=1 with length=0: done=1 next cycle; no reads; stays IDLE; underrun cleared.
  - sample_tick ignored.
- PREFETCH (one cycle): bram_en=1, bram_addr=rd_ptr → LOAD.
- LOAD (one cycle): bram_en=0; at the end of the cycle hold<=bram_dout → READY.
- READY, on sample_tick:
  - Next cycle: tx_data=hold, tx_valid=1, count+1, rd_ptr+1 modulo 2^ADDR_W (1023 wraps to 0).
  - If count+1==len → DRAIN, else → PREFETCH.
- DRAIN:
  - tx_data holds the last sample for one full tick period.
  - On the next sample_tick: tx_data=0, done=1 for one cycle, busy=0 → IDLE.
- Latency:
  - Accepted start at edge E0 → bram_en high in cycle E0..E1 → sample ready in READY from E2.
  - tick→tx_valid is one cycle.
  - sample_tick spacing ≥3 clk is guaranteed underrun-free.
- A sample_tick in PREFETCH or LOAD:
  - sets underrun=1 (held until the next accepted start);
  - the tick is dropped; the pending sample is emitted on the next tick in READY.
- start while busy is ignored; len/base are unaffected.
- sample_tick coincident with start in IDLE: start is accepted; the tick is ignored.
- busy=1 in PREFETCH, LOAD, READY and DRAIN; done and busy are never both 1.
- bram_en is asserted exactly once per sample; bram_addr holds its last value when bram_en=0.

Test Plan:
- Preload BRAM[100..103]=5,6,7,8; base=100, length=4; tick every 8 clk → tx_valid pulses 4×.
  - tx_data sequence 5,6,7,8; done one tick after sample 8; tx_data=0 with done; underrun=0.
  - Exactly 4 bram_en pulses, at addresses 100..103.
- Wrap: base=1022, length=4 → read addresses 1022, 1023, 0, 1; data in that order.
- Underrun: length=3, tick every 2 clk → underrun=1; all 3 samples still emitted in order.
  - Next start with tick every 3 clk → underrun cleared and stays 0.
- length=0 → done pulse the cycle after start; busy stays 0; no bram_en.
  - start pulsed mid-playback → ignored: same address and data sequence as without it.
- Assert rst_n=0 after sample 2 of 4 → all outputs 0 asynchronously; no done.
  - After release, a new start with base=200 plays correctly from address 200.

Source files
------------

// File: rtl/tx_wave_reader_if.sv
// Bus bundle for tx_wave_reader: playback control, BRAM read port and DAC sample stream.
// Pure wiring, adds no latency.
// No backpressure: DAC pacing comes from sample_tick, control from start/busy/done.
interface tx_wave_reader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18,
   parameter int LEN_W  = 11
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  length;
   logic              sample_tick;
   logic              bram_en;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_dout;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              busy;
   logic              done;
   logic              underrun;

   // Reader view: owns the BRAM read port and the DAC-side outputs.
   modport master (
      input  start, base_addr, length, sample_tick, bram_dout,
      output bram_en, bram_addr, tx_data, tx_valid, busy, done, underrun
   );

   // Environment view: controller, tick source, BRAM and DAC.
   modport slave (
      output start, base_addr, length, sample_tick, bram_dout,
      input  bram_en, bram_addr, tx_data, tx_valid, busy, done, underrun
   );
endinterface

// File: rtl/tx_wave_reader.sv
// Streams a stored waveform from the sample BRAM to the DAC, one sample per sample_tick.
// Latency: start -> first sample ready 2 clk; sample_tick -> tx_valid 1 clk.
// No backpressure: a tick arriving before the next sample is fetched is dropped and flags underrun.
module tx_wave_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18,
   parameter int LEN_W  = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   tx_wave_reader_if.master bus
);
   typedef enum logic [2:0] {IDLE, PREFETCH, LOAD, READY, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
   logic [LEN_W-1:0]  len, len_nxt;
   logic [LEN_W-1:0]  count, count_nxt, count_inc;
   logic [DATA_W-1:0] hold, hold_nxt;

   logic              bram_en_r, bram_en_nxt;
   logic [ADDR_W-1:0] bram_addr_r, bram_addr_nxt;
   logic [DATA_W-1:0] tx_data_r, tx_data_nxt;
   logic              tx_valid_r, tx_valid_nxt;
   logic              busy_r, busy_nxt;
   logic              done_r, done_nxt;
   logic              underrun_r, underrun_nxt;

   assign count_inc     = count + LEN_W'(1);

   assign bus.bram_en   = bram_en_r;
   assign bus.bram_addr = bram_addr_r;
   assign bus.tx_data   = tx_data_r;
   assign bus.tx_valid  = tx_valid_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.underrun  = underrun_r;

   // State register; reset mid-playback drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and next-output decode; every output is computed here and registered below.
   always_comb begin
      state_nxt     = state;
      rd_ptr_nxt    = rd_ptr;
      len_nxt       = len;
      count_nxt     = count;
      hold_nxt      = hold;
      bram_en_nxt   = 1'b0;
      bram_addr_nxt = bram_addr_r;
      tx_data_nxt   = tx_data_r;
      tx_valid_nxt  = 1'b0;
      done_nxt      = 1'b0;
      underrun_nxt  = underrun_r;
      case (state)
         IDLE: begin
            if (bus.start) begin
               underrun_nxt = 1'b0;
               if (bus.length != '0) begin
                  rd_ptr_nxt    = bus.base_addr;
                  len_nxt       = bus.length;
                  count_nxt     = '0;
                  bram_en_nxt   = 1'b1;
                  bram_addr_nxt = bus.base_addr;
                  state_nxt     = PREFETCH;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         PREFETCH: begin
            if (bus.sample_tick) underrun_nxt = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            if (bus.sample_tick) underrun_nxt = 1'b1;
            hold_nxt  = bus.bram_dout;
            state_nxt = READY;
         end
         READY: begin
            if (bus.sample_tick) begin
               tx_data_nxt  = hold;
               tx_valid_nxt = 1'b1;
               count_nxt    = count_inc;
               rd_ptr_nxt   = rd_ptr + ADDR_W'(1);
               if (count_inc == len) begin
                  state_nxt = DRAIN;
               end else begin
                  // Fetch of the next sample starts on the same edge the current one is shown.
                  bram_en_nxt   = 1'b1;
                  bram_addr_nxt = rd_ptr + ADDR_W'(1);
                  state_nxt     = PREFETCH;
               end
            end
         end
         DRAIN: begin
            if (bus.sample_tick) begin
               tx_data_nxt = '0;
               done_nxt    = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         len         <= '0;
         count       <= '0;
         hold        <= '0;
         bram_en_r   <= 1'b0;
         bram_addr_r <= '0;
         tx_data_r   <= '0;
         tx_valid_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         underrun_r  <= 1'b0;
      end else begin
         rd_ptr      <= rd_ptr_nxt;
         len         <= len_nxt;
         count       <= count_nxt;
         hold        <= hold_nxt;
         bram_en_r   <= bram_en_nxt;
         bram_addr_r <= bram_addr_nxt;
         tx_data_r   <= tx_data_nxt;
         tx_valid_r  <= tx_valid_nxt;
         busy_r      <= busy_nxt;
         done_r      <= done_nxt;
         underrun_r  <= underrun_nxt;
      end
   end
endmodule
